// File: rtl/disp_pipe_ctrl.sv
// Flow-control sequencer for the pipelined argmin disparity tree: valid/marker tracking, global stall, frame FSM.
// Optional build macro DISP_CTRL_STALL_CNT_EN adds o_stall_cnt (busy cycles spent stalled).
module disp_pipe_ctrl #(
    parameter int ELEM       = 64,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_eol,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        tree_c_en,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eol
`ifdef DISP_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] o_stall_cnt
`endif
);

    localparam int LAT = $clog2(ELEM);
    localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } mark_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [LAT-1:0]  vld_q;
    logic [LAT:0]    vld_nxt;
    mark_t [LAT-1:0] mark_q;
    mark_t [LAT:0]   mark_nxt;
    mark_t           in_mark;
    logic            accept, start_acc;
    logic            pos_sof, pos_eol, pos_last;

    assign m_valid   = vld_q[LAT-1];
    assign m_sof     = mark_q[LAT-1].sof;
    assign m_eol     = mark_q[LAT-1].eol;
    assign tree_c_en = ~m_valid | m_ready;
    assign s_ready   = tree_c_en & (state == RUN);
    assign accept    = s_valid & s_ready;
    assign start_acc = (state == IDLE) & i_start;
    assign o_busy    = (state != IDLE);

    assign pos_sof  = (col == '0) && (row == '0);
    assign pos_eol  = (col == CW'(IMG_WIDTH - 1));
    assign pos_last = pos_eol && (row == RW'(IMG_HEIGHT - 1));

    // Bubbles carry zero markers so idle stages never look like a line end.
    assign in_mark  = '{sof: pos_sof & accept, eol: pos_eol & accept};
    assign vld_nxt  = {vld_q, accept};
    assign mark_nxt = {mark_q, in_mark};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_q  <= '0;
            mark_q <= '0;
        end else if (tree_c_en) begin
            vld_q  <= vld_nxt[LAT-1:0];
            mark_q <= mark_nxt[LAT-1:0];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_eol) begin
                col <= '0;
                row <= pos_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Sticky marker-mismatch flag; the beat itself is still processed.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            o_err_eol <= 1'b0;
        else if (start_acc)
            o_err_eol <= 1'b0;
        else if (accept && ((s_sof != pos_sof) || (s_eol != pos_eol)))
            o_err_eol <= 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_done    = 1'b0;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (accept && pos_last) state_nxt = DRAIN;
            DRAIN: begin
                // m_valid is the last vld stage, so an empty vld means nothing is left to hand off.
                if (vld_q == '0) begin
                    o_done    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DISP_CTRL_STALL_CNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            o_stall_cnt <= '0;
        else if (start_acc)
            o_stall_cnt <= '0;
        else if (o_busy && !tree_c_en && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_disp_pipe_ctrl.sv
// Randomized and directed bench for disp_pipe_ctrl; a queue-of-ages model predicts every output each cycle.
module tb_disp_pipe_ctrl;
    localparam int LAT = 6;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = W * H;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic areset, i_start, s_valid, s_sof, s_eol, m_ready;
    logic o_busy, o_done, o_err_eol, s_ready, tree_c_en, m_valid, m_sof, m_eol;
    logic i_start1, s_valid1, s_sof1, s_eol1, m_ready1;
    logic o_busy1, o_done1, o_err1, s_ready1, en1, m_valid1, m_sof1, m_eol1;
`ifdef DISP_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt1;
`endif

    disp_pipe_ctrl #(.ELEM(64), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .aclk(aclk), .areset(areset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_err_eol(o_err_eol), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_eol(s_eol),
        .tree_c_en(tree_c_en), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol)
`ifdef DISP_CTRL_STALL_CNT_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    disp_pipe_ctrl #(.ELEM(64), .IMG_WIDTH(1), .IMG_HEIGHT(1)) dut1 (
        .aclk(aclk), .areset(areset), .i_start(i_start1), .o_busy(o_busy1), .o_done(o_done1),
        .o_err_eol(o_err1), .s_valid(s_valid1), .s_ready(s_ready1), .s_sof(s_sof1), .s_eol(s_eol1),
        .tree_c_en(en1), .m_valid(m_valid1), .m_ready(m_ready1), .m_sof(m_sof1), .m_eol(m_eol1)
`ifdef DISP_CTRL_STALL_CNT_EN
        , .o_stall_cnt(stall_cnt1)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Model: in-flight beats as ages (advancing edges since accept); age LAT is the output slot.
    bit     mb_busy;
    int     m_nacc;
    bit     m_err;
    longint m_stall;
    int     q_age[$];
    int     q_idx[$];

    int acc_cyc[$];
    int out_cyc[$];
    bit out_sof[$];
    bit out_eol[$];
    int done_cyc, done_cnt;

    always @(negedge aclk) begin
        bit e_mv, e_en, e_sr, e_done, acc, x_sof, x_eol;
        if (areset) begin
            mb_busy = 0; m_nacc = 0; m_err = 0; m_stall = 0;
            q_age.delete(); q_idx.delete();
            chk("rst m_valid", m_valid, 0);
            chk("rst o_busy", o_busy, 0);
            chk("rst tree_c_en", tree_c_en, 1);
            chk("rst o_done", o_done, 0);
            chk("rst s_ready", s_ready, 0);
            chk("rst o_err_eol", o_err_eol, 0);
        end else begin
            e_mv   = (q_age.size() > 0) && (q_age[0] == LAT);
            e_en   = !e_mv || m_ready;
            e_sr   = e_en && mb_busy && (m_nacc < N);
            e_done = mb_busy && (m_nacc == N) && (q_age.size() == 0);
            chk("m_valid", m_valid, e_mv);
            chk("tree_c_en", tree_c_en, e_en);
            chk("s_ready", s_ready, e_sr);
            chk("o_busy", o_busy, mb_busy);
            chk("o_done", o_done, e_done);
            chk("o_err_eol", o_err_eol, m_err);
`ifdef DISP_CTRL_STALL_CNT_EN
            chk("o_stall_cnt", stall_cnt, m_stall);
`endif
            if (e_mv) begin
                x_sof = (q_idx[0] == 0);
                x_eol = (q_idx[0] % W == W - 1);
                chk("m_sof", m_sof, x_sof);
                chk("m_eol", m_eol, x_eol);
            end
            if (s_valid && s_ready) acc_cyc.push_back(cyc);
            if (m_valid && m_ready) begin
                out_cyc.push_back(cyc); out_sof.push_back(m_sof); out_eol.push_back(m_eol);
            end
            if (o_done) begin done_cyc = cyc; done_cnt++; end
            acc = s_valid && e_sr;
            if (mb_busy && !e_en) m_stall++;
            if (e_en) begin
                if (e_mv) begin void'(q_age.pop_front()); void'(q_idx.pop_front()); end
                foreach (q_age[i]) q_age[i]++;
                if (acc) begin
                    if ((s_sof != (m_nacc == 0)) || (s_eol != (m_nacc % W == W - 1))) m_err = 1;
                    q_age.push_back(1); q_idx.push_back(m_nacc);
                    m_nacc++;
                end
            end
            if (e_done) mb_busy = 0;
            else if (!mb_busy && i_start) begin
                mb_busy = 1; m_nacc = 0; m_err = 0; m_stall = 0;
            end
        end
    end

    // Second instance (1x1 frame) is checked only against literal expectations.
    int o1_cnt, o1_cyc, a1_cyc, d1_cnt, d1_cyc;
    bit o1_sof, o1_eol;
    always @(negedge aclk) begin
        if (!areset) begin
            if (s_valid1 && s_ready1) a1_cyc = cyc;
            if (m_valid1 && m_ready1) begin o1_cnt++; o1_cyc = cyc; o1_sof = m_sof1; o1_eol = m_eol1; end
            if (o_done1) begin d1_cnt++; d1_cyc = cyc; end
        end
    end

    // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 ready, 1 stall c=10..14, 2 random.
    // emode: 0 correct markers, 1 eol moved from beat 3 to beat 2, 2 random marker errors.
    task automatic drive_frame(input int vmode, input int rmode, input int emode,
                               input int rst_at, input int budget);
        int c;
        bit rst_hit;
        acc_cyc.delete(); out_cyc.delete(); out_sof.delete(); out_eol.delete();
        done_cnt = 0; done_cyc = 0;
        @(posedge aclk); #1 i_start = 1; s_valid = 0; m_ready = 1;
        @(posedge aclk); #1 i_start = 0;
        chk("start clears o_err_eol", o_err_eol, 0);
        c = 0; rst_hit = 0;
        while (done_cnt == 0 && c < budget && !rst_hit) begin
            if (c > 0) begin @(posedge aclk); #1; end
            if (rst_at >= 0 && m_nacc == rst_at) begin
                areset = 1; #2;
                chk("async rst m_valid", m_valid, 0);
                chk("async rst o_busy", o_busy, 0);
                chk("async rst tree_c_en", tree_c_en, 1);
                chk("async rst o_done", o_done, 0);
                s_valid = 0; m_ready = 1;
                repeat (2) @(posedge aclk);
                #1 areset = 0;
                rst_hit = 1;
            end else begin
                case (vmode)
                    0: s_valid = 1;
                    1: s_valid = (c % 2 == 0);
                    default: s_valid = ($urandom % 4) != 0;
                endcase
                case (rmode)
                    0: m_ready = 1;
                    1: m_ready = !(c >= 10 && c < 15);
                    default: m_ready = ($urandom % 2) != 0;
                endcase
                s_sof = (m_nacc == 0);
                s_eol = (m_nacc % W == W - 1);
                if (emode == 1 && m_nacc == 2) s_eol = 1;
                if (emode == 1 && m_nacc == 3) s_eol = 0;
                if (emode == 2 && ($urandom % 8) == 0) s_eol = !s_eol;
                i_start = (vmode == 2) && (($urandom % 8) == 0);
                c++;
            end
        end
        #1 s_valid = 0; m_ready = 1; i_start = 0;
        if (!rst_hit) chk("frame done within budget", (c < budget), 1);
        @(posedge aclk); #1;
    endtask

    initial begin
        areset = 1; i_start = 0; s_valid = 0; s_sof = 0; s_eol = 0; m_ready = 1;
        i_start1 = 0; s_valid1 = 0; s_sof1 = 0; s_eol1 = 0; m_ready1 = 1;
        o1_cnt = 0; d1_cnt = 0; a1_cyc = 0; o1_cyc = 0; d1_cyc = 0; o1_sof = 0; o1_eol = 0;
        repeat (2) @(posedge aclk);
        #1 areset = 0;
        repeat (2) @(posedge aclk);

        // 1: back-to-back frame
        drive_frame(0, 0, 0, -1, 200);
        chk("t1 outputs", out_cyc.size(), 8);
        if (out_cyc.size() == 8 && acc_cyc.size() == 8) begin
            chk("t1 latency", out_cyc[0] - acc_cyc[0], 6);
            chk("t1 consecutive", out_cyc[7] - out_cyc[0], 7);
            chk("t1 sof0", out_sof[0], 1);
            chk("t1 eol2", out_eol[2], 0);
            chk("t1 eol3", out_eol[3], 1);
            chk("t1 eol7", out_eol[7], 1);
            chk("t1 done after last", done_cyc - out_cyc[7], 1);
        end
        chk("t1 idle", o_busy, 0);

        // 2: downstream stall of five cycles
        drive_frame(0, 1, 0, -1, 200);
        chk("t2 outputs", out_cyc.size(), 8);
        if (out_cyc.size() == 8) chk("t2 span", out_cyc[7] - out_cyc[0], 12);
`ifdef DISP_CTRL_STALL_CNT_EN
        chk("t2 stall_cnt", stall_cnt, 5);
`endif

        // 3: toggling input valid
        drive_frame(1, 0, 0, -1, 200);
        chk("t3 outputs", out_cyc.size(), 8);
        if (out_cyc.size() == 8 && acc_cyc.size() == 8) begin
            int bad = 0;
            foreach (out_cyc[i]) if (out_cyc[i] - acc_cyc[i] != 6) bad++;
            chk("t3 per-beat latency", bad, 0);
            chk("t3 gap", out_cyc[1] - out_cyc[0], 2);
        end

        // 4: eol on the wrong beat
        drive_frame(0, 0, 1, -1, 200);
        chk("t4 err sticky", o_err_eol, 1);
        if (out_eol.size() == 8) begin
            chk("t4 eol3", out_eol[3], 1);
            chk("t4 eol2", out_eol[2], 0);
            chk("t4 eol7", out_eol[7], 1);
        end

        // 5: reset after five accepts, then a clean frame
        drive_frame(0, 0, 0, 5, 200);
        repeat (10) @(posedge aclk);
        chk("t5 no done", done_cnt, 0);
        drive_frame(0, 0, 0, -1, 200);
        chk("t5 clean outputs", out_cyc.size(), 8);
        chk("t5 clean err", o_err_eol, 0);

        // random frames
        for (int f = 0; f < 8; f++) drive_frame(2, 2, (f % 2 == 0) ? 2 : 0, -1, 600);

        // 6: 1x1 frame with an extra start during RUN
        @(posedge aclk); #1 i_start1 = 1;
        @(posedge aclk); #1 i_start1 = 0;
        chk("t6 busy", o_busy1, 1);
        @(posedge aclk); #1 i_start1 = 1;
        @(posedge aclk); #1 i_start1 = 0; s_valid1 = 1; s_sof1 = 1; s_eol1 = 1;
        #2 chk("t6 s_ready", s_ready1, 1);
        @(posedge aclk); #1 s_valid1 = 0;
        #2 chk("t6 drain s_ready", s_ready1, 0);
        repeat (20) @(posedge aclk);
        #1;
        chk("t6 outputs", o1_cnt, 1);
        chk("t6 latency", o1_cyc - a1_cyc, 6);
        chk("t6 sof", o1_sof, 1);
        chk("t6 eol", o1_eol, 1);
        chk("t6 done count", d1_cnt, 1);
        chk("t6 done after out", d1_cyc - o1_cyc, 1);
        chk("t6 idle", o_busy1, 0);
        chk("t6 err", o_err1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
